readout_sched: RTL and testbench
================================

Name: readout_sched

Overview:
Sequences read-back of the sample memory to the UART transmitter once a capture has stopped. Walks the ring buffer newest-sample-first from the stop pointer, fetches each word over the synchronous memory read port and hands it to the transmitter with a strobe/ready handshake. Sits between the capture controller (start, stop pointer, read count) and the sample RAM / tx path of the core.

Parameters:
AW, 5, sample memory address width; DEPTH = 2**AW entries
DW, 32, sample/tx word width

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
start_i  in  1  one-cycle pulse: capture finished, begin readout
wr_ptr_i  in  AW  next write address at stop time (oldest sample); sampled on start
rd_cnt_i  in  AW+1  number of words to send; sampled on start
abort_i  in  1  cancel readout
rd_o  out  1  memory read enable
addr_o  out  AW  memory read address
mem_i  in  DW  memory read data, valid the cycle after rd_o
tx_rdy_i  in  1  transmitter can accept a word
tx_stb_o  out  1  word transfer strobe
tx_o  out  DW  word to transmit
busy_o  out  1  readout in progress
done_o  out  1  one-cycle pulse: readout finished normally

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset values: rd_o=0, addr_o=0, tx_stb_o=0, tx_o=0, busy_o=0, done_o=0; state IDLE. Reset mid-readout returns to IDLE on the next edge with no strobe or done pulse.
- States: IDLE, READ, LATCH, SEND, GAP, DONE.
- IDLE: on start_i=1, latch ptr=wr_ptr_i-1 (mod DEPTH) and cnt=min(rd_cnt_i, DEPTH). cnt=0 -> DONE, else -> READ. start_i outside IDLE is ignored.
- READ (1 cycle): rd_o=1, addr_o=ptr -> LATCH.
- LATCH (1 cycle): tx_o <= mem_i at end of cycle; ptr <= ptr-1 mod DEPTH (wraps 0 -> DEPTH-1); cnt <= cnt-1 -> SEND.
- SEND: tx_stb_o = tx_rdy_i (combinational, only in SEND). Stays in SEND while tx_rdy_i=0. On strobe: cnt=0 -> DONE, else -> GAP.
- GAP (1 cycle): no strobe, no read; gives the transmitter one cycle to drop tx_rdy_i -> READ.
- DONE (1 cycle): done_o=1 -> IDLE.
- busy_o=1 in READ, LATCH, SEND, GAP; 0 in IDLE and DONE.
- tx_o holds its value between LATCH updates, including after DONE.
- rd_o and addr_o only change in READ; addr_o holds its last value otherwise, rd_o=0.
- Timing with tx_rdy_i held 1: start in cycle 0; READ cycle 1; first strobe cycle 3; 4 cycles per word; done_o in cycle 4*N; IDLE in cycle 4*N+1.
- abort_i=1 in any non-IDLE state: next state IDLE, no done_o. tx_stb_o is forced 0 in the abort cycle. abort_i has priority over start and tx_rdy_i; abort_i in IDLE has no effect.
- rd_cnt_i > DEPTH is clamped to DEPTH; no word is sent twice.

Test Plan:
- Basic: wr_ptr_i=5, rd_cnt_i=3, tx_rdy_i=1 -> reads at addr 4,3,2. tx_o equals RAM contents of 4,3,2 at strobes in cycles 3,7,11. done_o in cycle 12. busy_o 1 in cycles 1..11.
- Wrap: wr_ptr_i=1, rd_cnt_i=4 -> addresses 0,31,30,29 in order; exactly 4 strobes.
- Backpressure: rd_cnt_i=2, tx_rdy_i low for 10 cycles in the first SEND -> no strobe, tx_o stable. Strobe in the first cycle tx_rdy_i rises. Second word follows after GAP/READ/LATCH.
- Edge counts: rd_cnt_i=0 -> done_o in cycle 1, no rd_o, no strobe. rd_cnt_i=40 with AW=5 -> exactly 32 strobes, every address read once.
- Abort/reset: abort_i asserted in the SEND cycle of the 2nd of 5 words -> no strobe that cycle, IDLE next, no done_o. A new start_i is accepted after that. rst_i mid-readout gives the same result, and all outputs take their reset values.
- Ignored start: start_i pulsed while busy_o=1 -> no effect on ptr, cnt or word count.

Source files
------------

// File: rtl/readout_sched.sv
// rtl/readout_sched.sv - newest-first ring buffer readout from sample RAM to the UART tx path
// Each word takes READ -> LATCH -> SEND (waits on tx_rdy_i) -> GAP; abort and reset drop straight to IDLE.
module readout_sched #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [AW-1:0] wr_ptr_i,
  input  logic [AW:0]   rd_cnt_i,
  input  logic          abort_i,
  output logic          rd_o,
  output logic [AW-1:0] addr_o,
  input  logic [DW-1:0] mem_i,
  input  logic          tx_rdy_i,
  output logic          tx_stb_o,
  output logic [DW-1:0] tx_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [AW:0] DEPTH_W = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [DW-1:0] tx_q, tx_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    tx_d     = tx_q;
    rd_o     = 1'b0;
    addr_o   = addr_q;
    tx_stb_o = 1'b0;
    busy_o   = 1'b0;
    done_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          // wr_ptr_i points at the oldest sample, so the newest is one behind it
          ptr_d   = wr_ptr_i - AW'(1);
          cnt_d   = (rd_cnt_i > DEPTH_W) ? DEPTH_W : rd_cnt_i;
          state_d = (cnt_d == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        busy_o  = 1'b1;
        rd_o    = 1'b1;
        addr_o  = ptr_q;
        addr_d  = ptr_q;
        state_d = S_LATCH;
      end
      S_LATCH: begin
        busy_o  = 1'b1;
        tx_d    = mem_i;
        ptr_d   = ptr_q - AW'(1);
        cnt_d   = cnt_q - (AW+1)'(1);
        state_d = S_SEND;
      end
      S_SEND: begin
        busy_o   = 1'b1;
        tx_stb_o = tx_rdy_i;
        if (tx_rdy_i) begin
          state_d = (cnt_q == '0) ? S_DONE : S_GAP;
        end
      end
      S_GAP: begin
        busy_o  = 1'b1;
        state_d = S_READ;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Cancellation must never leak a strobe or done pulse in the cycle it is seen
    if (rst_i || (abort_i && state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      tx_stb_o = 1'b0;
      done_o   = 1'b0;
    end
  end

  assign tx_o = tx_q;

endmodule

// File: tb/tb_readout_sched.sv
// tb/tb_readout_sched.sv - randomized self-checking bench for readout_sched against a word-order/timing model
module tb_readout_sched;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_i, start_i, abort_i, tx_rdy_i;
  logic [AW-1:0] wr_ptr_i;
  logic [AW:0]   rd_cnt_i;
  logic [DW-1:0] mem_i;
  logic          rd_o, tx_stb_o, busy_o, done_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] tx_o;

  always #5 clk = ~clk;

  readout_sched #(.AW(AW), .DW(DW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .wr_ptr_i(wr_ptr_i), .rd_cnt_i(rd_cnt_i),
    .abort_i(abort_i), .rd_o(rd_o), .addr_o(addr_o), .mem_i(mem_i), .tx_rdy_i(tx_rdy_i),
    .tx_stb_o(tx_stb_o), .tx_o(tx_o), .busy_o(busy_o), .done_o(done_o)
  );

  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) if (rd_o) mem_i <= ram[addr_o];

  int cyc = 0;
  int cyc0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] got_words[$];
  int got_scyc[$];
  int got_addr[$];
  int got_done[$];
  int busy_n;

  always @(negedge clk) begin
    if (tx_stb_o) begin
      got_words.push_back(tx_o);
      got_scyc.push_back(cyc - cyc0);
    end
    if (rd_o) got_addr.push_back(int'(addr_o));
    if (done_o) got_done.push_back(cyc - cyc0);
    if (busy_o) busy_n++;
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode: 0 tx_rdy=1, 1 random tx_rdy, 2 backpressure, 3 abort at ev, 4 reset at ev, 5 stray start at ev
  task automatic run_case(input string name, input int wp, input int rc, input int mode, input int ev);
    int n, exp_s, rel, end_rel, lim;
    logic [DW-1:0] held;
    bit fin;
    bit cancel;
    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
    n = (rc > DEPTH) ? DEPTH : rc;
    cancel = (mode == 3 || mode == 4);
    held = '0;
    got_words.delete(); got_scyc.delete(); got_addr.delete(); got_done.delete();
    busy_n = 0;

    @(posedge clk); #1;
    wr_ptr_i = wp[AW-1:0];
    rd_cnt_i = rc[AW:0];
    start_i  = 1'b1;
    tx_rdy_i = (mode == 2) ? 1'b0 : 1'b1;
    cyc0 = cyc;
    @(posedge clk); #1;
    start_i  = 1'b0;
    wr_ptr_i = AW'($urandom);
    rd_cnt_i = (AW+1)'($urandom);

    rel = 1; fin = 0; end_rel = -1;
    while (!fin) begin
      case (mode)
        1: tx_rdy_i = 1'($urandom_range(0, 1));
        2: tx_rdy_i = (rel >= 13);
        3: abort_i  = (rel == ev);
        4: rst_i    = (rel == ev);
        5: start_i  = (rel == ev);
        default: ;
      endcase
      @(negedge clk);
      if (mode == 2 && rel == 3) held = tx_o;
      if (mode == 2 && rel == 12) begin
        check_eq({name, " tx_o stable"}, tx_o, held);
        check_eq({name, " held word"}, held, ram[(wp - 1) & (DEPTH - 1)]);
      end
      if (cancel && rel == ev + 1) begin
        check_eq({name, " busy after cancel"}, busy_o, 0);
        check_eq({name, " stb after cancel"}, tx_stb_o, 0);
        if (mode == 4) begin
          check_eq({name, " rd reset"}, rd_o, 0);
          check_eq({name, " addr reset"}, addr_o, 0);
          check_eq({name, " tx reset"}, tx_o, 0);
          check_eq({name, " done reset"}, done_o, 0);
        end
      end
      if (end_rel < 0 && (got_done.size() > 0 || (cancel && rel > ev))) end_rel = rel + 2;
      if (rel == end_rel) fin = 1;
      if (rel > 3000) begin
        check_eq({name, " timeout"}, 1, 0);
        fin = 1;
      end
      @(posedge clk); #1;
      abort_i = 1'b0; rst_i = 1'b0; start_i = 1'b0;
      rel++;
    end

    exp_s = n;
    if (cancel) begin
      exp_s = 0;
      for (int i = 0; i < n; i++) if (4 * i + 3 < ev) exp_s++;
    end
    check_eq({name, " strobe count"}, got_words.size(), exp_s);
    lim = (got_words.size() < exp_s) ? got_words.size() : exp_s;
    for (int i = 0; i < lim; i++) begin
      check_eq({name, " word"}, got_words[i], ram[(wp - 1 - i) & (DEPTH - 1)]);
      if (mode == 2) check_eq({name, " strobe cycle"}, got_scyc[i], (i == 0) ? 13 : 17);
      else if (mode != 1) check_eq({name, " strobe cycle"}, got_scyc[i], 4 * i + 3);
    end
    check_eq({name, " done count"}, got_done.size(), cancel ? 0 : 1);
    if (!cancel && got_done.size() > 0 && mode != 1)
      check_eq({name, " done cycle"}, got_done[0], (mode == 2) ? 18 : ((n == 0) ? 1 : 4 * n));
    if (!cancel) begin
      check_eq({name, " read count"}, got_addr.size(), n);
      lim = (got_addr.size() < n) ? got_addr.size() : n;
      for (int i = 0; i < lim; i++)
        check_eq({name, " read addr"}, got_addr[i], (wp - 1 - i) & (DEPTH - 1));
      if (n > 0) check_eq({name, " tx_o hold"}, tx_o, ram[(wp - n) & (DEPTH - 1)]);
    end
    if (mode == 0 || mode == 5) check_eq({name, " busy cycles"}, busy_n, (n == 0) ? 0 : 4 * n - 1);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; tx_rdy_i = 1'b0;
    wr_ptr_i = '0; rd_cnt_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check_eq("reset rd_o", rd_o, 0);
    check_eq("reset addr_o", addr_o, 0);
    check_eq("reset tx_stb_o", tx_stb_o, 0);
    check_eq("reset tx_o", tx_o, 0);
    check_eq("reset busy_o", busy_o, 0);
    check_eq("reset done_o", done_o, 0);

    run_case("basic", 5, 3, 0, 0);
    run_case("wrap", 1, 4, 0, 0);
    run_case("zero", 7, 0, 0, 0);
    run_case("clamp", 9, 40, 0, 0);
    run_case("full", 0, 32, 0, 0);
    run_case("backpressure", 12, 2, 2, 0);
    run_case("abort", 20, 5, 3, 7);
    run_case("restart", 3, 6, 0, 0);
    run_case("reset", 17, 5, 4, 11);
    run_case("after reset", 30, 3, 0, 0);
    run_case("stray start", 8, 4, 5, 6);
    for (int k = 0; k < 20; k++)
      run_case("random", $urandom_range(0, 31), $urandom_range(0, 63), 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
